lsu_dmem: RTL and testbench

- Load/store unit with private data memory for the MEM stage of the RV32I pipeline.
- It is the producer of the load word consumed by the writeback select path: it accepts one load or store per request, performs byte/halfword/word access, and returns aligned, sign/zero-extended load data.
- It issues a stall while a load is outstanding.
- It flags misaligned and illegal-funct3 requests.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_ld_align.sv | 27 ++
 rtl/lsu_dmem.sv | 148 ++++++++++++++
 tb/tb_lsu_dmem.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access alignment rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } lsu_state_t;

  // Byte accesses are always aligned; halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return ~addr_lo[0];
      F3_W:        return (addr_lo == 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load formatter: picks the byte/halfword lane from a memory word and
// sign- or zero-extends it according to the load funct3.
module lsu_ld_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'd0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'd0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_dmem.sv
// MEM-stage load/store unit with private word-wide data memory. Stores
// complete in the accept cycle; loads stall the pipe until ld_valid.
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        lsu_err,
  output logic        stall
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [1:0] CNT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  lsu_state_t  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        lsu_err_q, lsu_err_d;

  logic              accept, f3_legal, req_ok, st_go, ld_go;
  logic [ADDR_W-1:0] widx;
  logic [3:0]        be;
  logic [31:0]       wdata_lane;
  logic [31:0]       fmt_data;
  logic              unused_addr;

  // Upper address bits alias onto the same memory.
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign widx        = req_addr[ADDR_W+1:2];

  always_comb begin
    req_ready = (state_q == IDLE);
    accept    = req_valid & req_ready;
    if (req_we) f3_legal = (req_funct3 == F3_B) | (req_funct3 == F3_H) | (req_funct3 == F3_W);
    else        f3_legal = (req_funct3 == F3_B) | (req_funct3 == F3_H) | (req_funct3 == F3_W) |
                           (req_funct3 == F3_BU) | (req_funct3 == F3_HU);
    req_ok = f3_legal & is_aligned(req_funct3, req_addr[1:0]);
    st_go  = accept & req_we & req_ok & ~rst;
    ld_go  = accept & ~req_we & req_ok;
    stall  = ld_go | (state_q == BUSY);
  end

  always_comb begin
    case (req_funct3)
      F3_B: begin
        be         = 4'b0001 << req_addr[1:0];
        wdata_lane = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        be         = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{req_wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (st_go) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
    if (ld_go) rdata_q <= mem_q[widx];
  end

  lsu_ld_align u_align (
    .word    (rdata_q),
    .addr_lo (addr_lo_q),
    .funct3  (f3_q),
    .result  (fmt_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_lo_d = addr_lo_q;
    f3_d      = f3_q;
    ld_data_d = ld_data_q;
    lsu_err_d = accept & ~req_ok;
    case (state_q)
      IDLE: begin
        if (ld_go) begin
          addr_lo_d = req_addr[1:0];
          f3_d      = req_funct3;
          if (MEM_LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 2'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      RESP: begin
        ld_data_d = fmt_data;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // During RESP the freshly formatted word is presented directly; afterwards the held copy.
  assign ld_valid = (state_q == RESP);
  assign ld_data  = (state_q == RESP) ? fmt_data : ld_data_q;
  assign lsu_err  = lsu_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      ld_data_q <= 32'd0;
      lsu_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_data_q <= ld_data_d;
      lsu_err_q <= lsu_err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_lo_q <= addr_lo_d;
    f3_q      <= f3_d;
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: two instances (MEM_LAT=1 and MEM_LAT=3) checked against
// a byte-array memory model, with directed cases followed by random traffic.
module tb_lsu_dmem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] ld_data    [2];
  logic        ld_valid   [2];
  logic        lsu_err    [2];
  logic        stall      [2];

  logic [7:0] mdl [2][4096];
  int checks = 0;
  int errors = 0;

  lsu_dmem #(.ADDR_W(10), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_funct3(req_funct3[0]), .ld_data(ld_data[0]), .ld_valid(ld_valid[0]),
    .lsu_err(lsu_err[0]), .stall(stall[0])
  );

  lsu_dmem #(.ADDR_W(10), .MEM_LAT(3)) dut_lat3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_funct3(req_funct3[1]), .ld_data(ld_data[1]), .ld_valid(ld_valid[1]),
    .lsu_err(lsu_err[1]), .stall(stall[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit f3ok;
    int sz;
    if (we) f3ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    f3ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return f3ok && ((int'(a[1:0]) % sz) == 0);
  endfunction

  function automatic logic [31:0] mdl_load(input int d, input logic [31:0] a, input logic [2:0] f3);
    int b, bw, hb;
    logic [7:0]  by;
    logic [15:0] h;
    logic [31:0] w;
    b  = int'(a[11:0]);
    bw = b - (b % 4);
    hb = b - (b % 2);
    by = mdl[d][b];
    h  = {mdl[d][hb+1], mdl[d][hb]};
    w  = {mdl[d][bw+3], mdl[d][bw+2], mdl[d][bw+1], mdl[d][bw]};
    case (f3)
      3'd0:    return int'($signed(by));
      3'd4:    return {24'd0, by};
      3'd1:    return int'($signed(h));
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic mdl_store(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    int b;
    int n;
    b = int'(a[11:0]);
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) mdl[d][b+i] = wd[8*i +: 8];
  endtask

  task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, output logic [31:0] got);
    bit ok;
    int lat;
    logic [31:0] exp;
    ok  = legal(we, f3, a);
    lat = (d == 1) ? 3 : 1;
    exp = '0;
    got = '0;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_funct3[d] = f3;
    if (!we && ok) exp = mdl_load(d, a, f3);
    @(negedge clk);
    chk("ready_at_accept", req_ready[d], 1);
    chk("stall_at_accept", stall[d], (!we && ok));
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    if (!ok) begin
      @(negedge clk);
      chk("err_pulse", lsu_err[d], 1);
      chk("no_valid_on_err", ld_valid[d], 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_one_cycle", lsu_err[d], 0);
      @(posedge clk); #1;
    end else if (we) begin
      mdl_store(d, a, wd, f3);
      @(negedge clk);
      chk("store_no_err", lsu_err[d], 0);
      chk("store_no_stall", stall[d], 0);
      chk("store_ready", req_ready[d], 1);
      @(posedge clk); #1;
    end else begin
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        if (k < lat) begin
          chk("busy_stall", stall[d], 1);
          chk("busy_not_ready", req_ready[d], 0);
          chk("busy_no_valid", ld_valid[d], 0);
        end else begin
          chk("resp_valid", ld_valid[d], 1);
          chk("resp_data", ld_data[d], exp);
          chk("resp_no_stall", stall[d], 0);
          got = ld_data[d];
        end
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk("valid_one_cycle", ld_valid[d], 0);
      chk("data_held", ld_data[d], exp);
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] got, old, a, wd;
  logic [2:0]  f3;
  bit          we, seen_valid;
  logic [2:0]  ld_f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; req_funct3[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", req_ready[d], 1);
      chk("rst_valid", ld_valid[d], 0);
      chk("rst_err", lsu_err[d], 0);
      chk("rst_data", ld_data[d], 0);
      chk("rst_stall", stall[d], 0);
    end
    @(posedge clk); #1;

    // Directed MEM_LAT=1 cases
    txn(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, got);
    txn(0, 0, 32'h10, 32'h0, 3'b010, got); chk("lw_basic", got, 32'hDEADBEEF);
    txn(0, 0, 32'h13, 32'h0, 3'b000, got); chk("lb_13", got, 32'hFFFFFFDE);
    txn(0, 0, 32'h13, 32'h0, 3'b100, got); chk("lbu_13", got, 32'h000000DE);
    txn(0, 0, 32'h12, 32'h0, 3'b001, got); chk("lh_12", got, 32'hFFFFDEAD);
    txn(0, 0, 32'h10, 32'h0, 3'b101, got); chk("lhu_10", got, 32'h0000BEEF);
    txn(0, 1, 32'h11, 32'h12345678, 3'b000, got);
    txn(0, 0, 32'h10, 32'h0, 3'b010, got); chk("sb_merge", got, 32'hDEAD78EF);
    txn(0, 1, 32'h12, 32'h0000CAFE, 3'b001, got);
    txn(0, 0, 32'h10, 32'h0, 3'b010, got); chk("sh_merge", got, 32'hCAFE78EF);
    txn(0, 0, 32'h12, 32'h0, 3'b010, got);
    txn(0, 1, 32'h11, 32'hFFFFFFFF, 3'b001, got);
    txn(0, 0, 32'h10, 32'h0, 3'b010, got); chk("after_bad_sh", got, 32'hCAFE78EF);
    txn(0, 0, 32'h10, 32'h0, 3'b011, got);

    // MEM_LAT=3: plain load, then a store held through BUSY/RESP
    txn(1, 1, 32'h10, 32'h11223344, 3'b010, got);
    txn(1, 0, 32'h10, 32'h0, 3'b010, got); chk("lat3_lw", got, 32'h11223344);
    old = mdl_load(1, 32'h10, 3'b010);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h10; req_funct3[1] = 3'b010;
    @(negedge clk); chk("hold_accept_stall", stall[1], 1);
    @(posedge clk); #1;
    req_we[1] = 1'b1; req_wdata[1] = 32'hA5A50F0F;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("held_store_not_ready", req_ready[1], 0);
      if (k < 3) chk("held_store_stall", stall[1], 1);
      else       chk("held_load_data", ld_data[1], old);
      @(posedge clk); #1;
    end
    @(negedge clk); chk("held_store_ready", req_ready[1], 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    mdl_store(1, 32'h10, 32'hA5A50F0F, 3'b010);
    txn(1, 0, 32'h10, 32'h0, 3'b010, got); chk("held_store_landed", got, 32'hA5A50F0F);

    // MEM_LAT=3: reset in first BUSY cycle aborts the load
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h10; req_funct3[1] = 3'b010;
    @(posedge clk); #1;
    req_valid[1] = 1'b0; rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("abort_ready", req_ready[1], 1);
    chk("abort_data", ld_data[1], 0);
    chk("abort_stall", stall[1], 0);
    seen_valid = ld_valid[1];
    repeat (5) begin
      @(negedge clk);
      seen_valid = seen_valid | ld_valid[1];
    end
    chk("abort_no_valid", seen_valid, 0);
    @(posedge clk); #1;

    // Random traffic on both latencies
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 32; w++) txn(d, 1, 32'(w * 4), $urandom, 3'b010, got);
      for (int n = 0; n < 60; n++) begin
        a  = $urandom;
        a[11:7] = 5'd0;
        wd = $urandom;
        we = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
        else if (we)                   f3 = 3'($urandom_range(0, 2));
        else                           f3 = ld_f3s[$urandom_range(0, 4)];
        txn(d, we, a, wd, f3, got);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
